proc_run_checker: RTL

Synthesizable run controller and result checker for the pipelined ARMv8 core (PipelinedProc). It drives the core's reset and start PC and watches FetchedPC. When the PC reaches each programmed checkpoint, it waits for writeback, then compares dMemOut against an expected value. It reports the pass count, the first failure and a watchdog timeout. This lets the program-level checks run on hardware and in regression without a behavioural bench.

---
 rtl/proc_run_checker_if.sv | 42 ++++
 rtl/proc_run_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_checker_if.sv
// proc_run_checker_if
//   Groups the run-checker's configuration, core-facing and status signals.
//   master : testbench / host side (drives config + core feedback, reads status)
//   slave  : proc_run_checker side
//   Config  : start, cfg_we, cfg_idx, cfg_pc, cfg_val, cfg_start_pc
//   Core in : FetchedPC, dMemOut
//   Core out: proc_rst_n, startPC
//   Status  : busy, done, all_passed, timeout, pass_cnt, fail_valid, fail_idx, fail_data
interface proc_run_checker_if #(
    parameter int IDXW = 1
);
    logic            start;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic [63:0]     cfg_pc;
    logic [63:0]     cfg_val;
    logic [63:0]     cfg_start_pc;
    logic [63:0]     FetchedPC;
    logic [63:0]     dMemOut;
    logic            proc_rst_n;
    logic [63:0]     startPC;
    logic            busy;
    logic            done;
    logic            all_passed;
    logic            timeout;
    logic [7:0]      pass_cnt;
    logic            fail_valid;
    logic [IDXW-1:0] fail_idx;
    logic [63:0]     fail_data;

    modport master (
        output start, cfg_we, cfg_idx, cfg_pc, cfg_val, cfg_start_pc, FetchedPC, dMemOut,
        input  proc_rst_n, startPC, busy, done, all_passed, timeout, pass_cnt,
               fail_valid, fail_idx, fail_data
    );

    modport slave (
        input  start, cfg_we, cfg_idx, cfg_pc, cfg_val, cfg_start_pc, FetchedPC, dMemOut,
        output proc_rst_n, startPC, busy, done, all_passed, timeout, pass_cnt,
               fail_valid, fail_idx, fail_data
    );
endinterface

// File: rtl/proc_run_checker.sv
// proc_run_checker
//   Run controller and result checker for the pipelined core. On start it
//   holds the core in reset for RST_HOLD cycles, releases it at startPC, then
//   watches FetchedPC. Each time the PC reaches the current checkpoint it
//   waits WB_DELAY cycles for writeback, compares dMemOut with the expected
//   value and moves to the next checkpoint. A watchdog aborts runs that take
//   WATCHDOG cycles or more.
//   Ports:
//     Clk  : clock
//     Rst  : asynchronous active-high reset (clears table and all status)
//     bus  : proc_run_checker_if.slave (config, core feedback, status outputs)
//   All outputs are registered.
module proc_run_checker #(
    parameter int NUM_CHECKS = 2,
    parameter int RST_HOLD   = 5,
    parameter int WB_DELAY   = 4,
    parameter int WATCHDOG   = 65535,
    parameter int IDXW       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    proc_run_checker_if.slave    bus
);

    localparam int TBL_DEPTH = 2 ** IDXW;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        WBWAIT,
        CMP,
        DONE,
        TMO
    } stateT;

    stateT           state, stateNext;

    logic [63:0]     tblPc  [TBL_DEPTH];
    logic [63:0]     tblVal [TBL_DEPTH];
    logic            tblWe;

    logic [IDXW-1:0] idx, idxNext;
    logic [31:0]     holdCnt, holdCntNext;
    logic [31:0]     wbCnt, wbCntNext;
    logic [31:0]     wdog, wdogNext;
    logic            procRstN, procRstNNext;
    logic [63:0]     startPcR, startPcNext;
    logic            busyR, busyNext;
    logic            doneR, doneNext;
    logic            allPassed, allPassedNext;
    logic            timeoutR, timeoutNext;
    logic [7:0]      passCnt, passCntNext;
    logic            failValid, failValidNext;
    logic [IDXW-1:0] failIdx, failIdxNext;
    logic [63:0]     failData, failDataNext;

    logic [31:0]     wdogInc;
    logic            wdogHit;
    logic            pcHit;
    logic            valMatch;
    logic [7:0]      passInc;
    logic            active;

    // Checkpoint table; only writable while no run is in progress.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                tblPc[i]  <= '0;
                tblVal[i] <= '0;
            end
        end else if (tblWe) begin
            tblPc[bus.cfg_idx]  <= bus.cfg_pc;
            tblVal[bus.cfg_idx] <= bus.cfg_val;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            idx       <= '0;
            holdCnt   <= '0;
            wbCnt     <= '0;
            wdog      <= '0;
            procRstN  <= 1'b0;
            startPcR  <= '0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            allPassed <= 1'b0;
            timeoutR  <= 1'b0;
            passCnt   <= '0;
            failValid <= 1'b0;
            failIdx   <= '0;
            failData  <= '0;
        end else begin
            state     <= stateNext;
            idx       <= idxNext;
            holdCnt   <= holdCntNext;
            wbCnt     <= wbCntNext;
            wdog      <= wdogNext;
            procRstN  <= procRstNNext;
            startPcR  <= startPcNext;
            busyR     <= busyNext;
            doneR     <= doneNext;
            allPassed <= allPassedNext;
            timeoutR  <= timeoutNext;
            passCnt   <= passCntNext;
            failValid <= failValidNext;
            failIdx   <= failIdxNext;
            failData  <= failDataNext;
        end
    end

    always_comb begin
        stateNext     = state;
        idxNext       = idx;
        holdCntNext   = holdCnt;
        wbCntNext     = wbCnt;
        wdogNext      = wdog;
        procRstNNext  = procRstN;
        startPcNext   = startPcR;
        busyNext      = busyR;
        doneNext      = doneR;
        allPassedNext = allPassed;
        timeoutNext   = timeoutR;
        passCntNext   = passCnt;
        failValidNext = failValid;
        failIdxNext   = failIdx;
        failDataNext  = failData;
        tblWe         = 1'b0;

        wdogInc  = wdog + 32'd1;
        wdogHit  = (wdogInc >= 32'(WATCHDOG));
        pcHit    = (bus.FetchedPC >= tblPc[idx]);
        valMatch = (bus.dMemOut == tblVal[idx]);
        passInc  = (passCnt == 8'hFF) ? passCnt : passCnt + 8'd1;
        active   = (state == HOLD) || (state == RUN) || (state == WBWAIT) || (state == CMP);

        case (state)
            IDLE, DONE, TMO: begin
                tblWe = bus.cfg_we && (32'(bus.cfg_idx) < 32'(NUM_CHECKS));
                if (bus.start) begin
                    stateNext     = HOLD;
                    startPcNext   = bus.cfg_start_pc;
                    doneNext      = 1'b0;
                    allPassedNext = 1'b0;
                    timeoutNext   = 1'b0;
                    passCntNext   = '0;
                    failValidNext = 1'b0;
                    failIdxNext   = '0;
                    failDataNext  = '0;
                    idxNext       = '0;
                    wdogNext      = '0;
                    holdCntNext   = '0;
                    busyNext      = 1'b1;
                    procRstNNext  = 1'b0;
                end
            end
            HOLD: begin
                wdogNext = wdogInc;
                if (holdCnt + 32'd1 >= 32'(RST_HOLD)) begin
                    stateNext    = RUN;
                    procRstNNext = 1'b1;
                end else begin
                    holdCntNext = holdCnt + 32'd1;
                end
            end
            RUN: begin
                wdogNext = wdogInc;
                if (pcHit) begin
                    wbCntNext = 32'(WB_DELAY);
                    stateNext = (WB_DELAY == 0) ? CMP : WBWAIT;
                end
            end
            WBWAIT: begin
                wdogNext = wdogInc;
                // Counter was loaded with WB_DELAY on the hit; leaving on the
                // count of 1 puts the CMP sample WB_DELAY+1 cycles after the hit.
                if (wbCnt <= 32'd1) begin
                    stateNext = CMP;
                end else begin
                    wbCntNext = wbCnt - 32'd1;
                end
            end
            CMP: begin
                wdogNext = wdogInc;
                if (valMatch) begin
                    passCntNext = passInc;
                end else if (!failValid) begin
                    failValidNext = 1'b1;
                    failIdxNext   = idx;
                    failDataNext  = bus.dMemOut;
                end
                if (32'(idx) == 32'(NUM_CHECKS - 1)) begin
                    stateNext     = DONE;
                    doneNext      = 1'b1;
                    busyNext      = 1'b0;
                    allPassedNext = (passCntNext == 8'(NUM_CHECKS));
                end else begin
                    idxNext   = idx + IDXW'(1);
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Watchdog expiry overrides whatever the active state decided above,
        // including discarding a same-cycle CMP result.
        if (active && wdogHit) begin
            stateNext     = TMO;
            timeoutNext   = 1'b1;
            busyNext      = 1'b0;
            procRstNNext  = 1'b0;
            doneNext      = 1'b0;
            allPassedNext = 1'b0;
            idxNext       = idx;
            passCntNext   = passCnt;
            failValidNext = failValid;
            failIdxNext   = failIdx;
            failDataNext  = failData;
        end
    end

    assign bus.proc_rst_n = procRstN;
    assign bus.startPC    = startPcR;
    assign bus.busy       = busyR;
    assign bus.done       = doneR;
    assign bus.all_passed = allPassed;
    assign bus.timeout    = timeoutR;
    assign bus.pass_cnt   = passCnt;
    assign bus.fail_valid = failValid;
    assign bus.fail_idx   = failIdx;
    assign bus.fail_data  = failData;

endmodule
